vec_alu_multilane: RTL and testbench

VEC_ALU_MULTILANE -- requirements
Module: vec_alu_multilane

---
 rtl/vec_alu_pkg.sv | 79 +++++++
 rtl/vec_alu_beat.sv | 40 ++++
 rtl/vec_alu_multilane.sv | 155 +++++++++++++++
 tb/tb_vec_alu_multilane.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared encodings and helper functions for the multi-lane vector ALU.
package vec_alu_pkg;

    typedef enum logic [5:0] {
        OP_VADD  = 6'b000000,
        OP_VSUB  = 6'b000010,
        OP_VRSUB = 6'b000011,
        OP_VMINU = 6'b000100,
        OP_VMIN  = 6'b000101,
        OP_VMAXU = 6'b000110,
        OP_VMAX  = 6'b000111,
        OP_VAND  = 6'b001001,
        OP_VOR   = 6'b001010,
        OP_VXOR  = 6'b001011
    } op_e;

    typedef enum logic [2:0] {
        OPT_VV = 3'b001,
        OPT_VX = 3'b010,
        OPT_VI = 3'b100
    } optype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when the opcode / operand type / element width combination is supported.
    function automatic logic is_legal(input logic [5:0] opc, input logic [2:0] opt,
                                      input logic [2:0] sew);
        logic opc_ok;
        logic opt_ok;
        case (opc)
            OP_VADD, OP_VSUB, OP_VRSUB, OP_VMINU, OP_VMIN,
            OP_VMAXU, OP_VMAX, OP_VAND, OP_VOR, OP_VXOR: opc_ok = 1'b1;
            default:                                     opc_ok = 1'b0;
        endcase
        opt_ok = (opt == OPT_VV) || (opt == OPT_VX) || (opt == OPT_VI);
        return opc_ok && opt_ok && !sew[2] && !((opc == OP_VRSUB) && (opt == OPT_VV));
    endfunction

    // Element operation on left-aligned operands: the element's MSB sits at bit 63
    // and the unused low bits are zero, so one 64-bit add/compare serves every width.
    function automatic logic [63:0] alu_op(input logic [5:0] opc, input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0] r;
        case (opc)
            OP_VADD:  r = a + b;
            OP_VSUB:  r = a - b;
            OP_VRSUB: r = b - a;
            OP_VMINU: r = (a < b) ? a : b;
            OP_VMIN:  r = ($signed(a) < $signed(b)) ? a : b;
            OP_VMAXU: r = (a > b) ? a : b;
            OP_VMAX:  r = ($signed(a) > $signed(b)) ? a : b;
            OP_VAND:  r = a & b;
            OP_VOR:   r = a | b;
            OP_VXOR:  r = a ^ b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Scalar operand (rs1 or sign-extended imm) replicated across a 64-bit word at the element width.
    function automatic logic [63:0] scalar_pattern(input logic [2:0] opt, input logic [1:0] sew,
                                                   input logic [31:0] rs1, input logic [4:0] imm);
        logic [63:0] s;
        logic [63:0] p;
        s = (opt == OPT_VI) ? {{59{imm[4]}}, imm} : {{32{rs1[31]}}, rs1};
        case (sew)
            2'd0:    p = {8{s[7:0]}};
            2'd1:    p = {4{s[15:0]}};
            2'd2:    p = {2{s[31:0]}};
            default: p = s;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vec_alu_beat.sv
// Combinational packed-SIMD slice: one beat of elements, no carries across element boundaries.
module vec_alu_beat
    import vec_alu_pkg::*;
#(
    parameter int BW = 64
) (
    input  logic [5:0]    opcode,
    input  logic [1:0]    vsew,
    input  logic [BW-1:0] op1,
    input  logic [BW-1:0] vs2,
    output logic [BW-1:0] res
);

    logic [63:0] t;

    // Per-element evaluation for the selected element width.
    always_comb begin
        res = '0;
        t   = '0;
        case (vsew)
            2'd0: for (int i = 0; i < BW / 8; i++) begin
                t = alu_op(opcode, {vs2[i*8 +: 8], 56'd0}, {op1[i*8 +: 8], 56'd0});
                res[i*8 +: 8] = t[63:56];
            end
            2'd1: for (int i = 0; i < BW / 16; i++) begin
                t = alu_op(opcode, {vs2[i*16 +: 16], 48'd0}, {op1[i*16 +: 16], 48'd0});
                res[i*16 +: 16] = t[63:48];
            end
            2'd2: for (int i = 0; i < BW / 32; i++) begin
                t = alu_op(opcode, {vs2[i*32 +: 32], 32'd0}, {op1[i*32 +: 32], 32'd0});
                res[i*32 +: 32] = t[63:32];
            end
            default: for (int i = 0; i < BW / 64; i++) begin
                t = alu_op(opcode, vs2[i*64 +: 64], op1[i*64 +: 64]);
                res[i*64 +: 64] = t;
            end
        endcase
    end

endmodule

// File: rtl/vec_alu_multilane.sv
// Multi-cycle vector ALU: latches a request, processes one BW-wide beat per RUN cycle,
// merges results with the prior destination under mask/tail rules, pulses done.
module vec_alu_multilane
    import vec_alu_pkg::*;
#(
    parameter int VLEN      = 128,
    parameter int LANE_BITS = 16,
    parameter int NB_LANES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [5:0]             opcode,
    input  logic [2:0]             op_type,
    input  logic [2:0]             vsew,
    input  logic                   vm,
    input  logic [$clog2(VLEN):0]  vl,
    input  logic [VLEN-1:0]        vs1,
    input  logic [VLEN-1:0]        vs2,
    input  logic [VLEN-1:0]        v0,
    input  logic [VLEN-1:0]        vd_old,
    input  logic [31:0]            rs1,
    input  logic [4:0]             imm,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal,
    output logic [VLEN-1:0]        vd
);

    localparam int BW  = NB_LANES * LANE_BITS;
    localparam int B   = VLEN / BW;
    localparam int CW  = (B > 1) ? $clog2(B) : 1;
    localparam int VLW = $clog2(VLEN) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            legal, accept;

    logic [5:0]      opc_q;
    logic [1:0]      sew_q;
    logic            vm_q, vv_q;
    logic [VLW-1:0]  vl_q;
    logic [VLEN-1:0] vs1_q, vs2_q, v0_q, vdo_q;
    logic [63:0]     scal_q;
    logic [VLEN-1:0] vd_q;
    logic            ill_q;

    logic [BW-1:0]   vs1_b, vs2_b, vdo_b, op1_b, res_b, merged_b;
    logic [31:0]     g, idx, vl32, vlmax;
    logic            act;

    assign legal  = is_legal(opcode, op_type, vsew);
    assign accept = (state_q == ST_IDLE) && start;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = legal ? ST_RUN : ST_DONE;
            ST_RUN:  if (cnt_q == CW'(B - 1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Beat counter, counts only while running.
    always_ff @(posedge clk) begin
        if (reset || (state_q != ST_RUN)) cnt_q <= '0;
        else                              cnt_q <= cnt_q + 1'b1;
    end

    // Operand capture on an accepted request; the scalar operand is pre-replicated here.
    always_ff @(posedge clk) begin
        if (accept) begin
            opc_q  <= opcode;
            sew_q  <= vsew[1:0];
            vm_q   <= vm;
            vv_q   <= (op_type == OPT_VV);
            vl_q   <= vl;
            vs1_q  <= vs1;
            vs2_q  <= vs2;
            v0_q   <= v0;
            vdo_q  <= vd_old;
            scal_q <= scalar_pattern(op_type, vsew[1:0], rs1, imm);
        end
    end

    // Select the current beat of each vector operand.
    always_comb begin
        vs1_b = '0;
        vs2_b = '0;
        vdo_b = '0;
        for (int k = 0; k < B; k++) begin
            if (cnt_q == CW'(k)) begin
                vs1_b = vs1_q[k*BW +: BW];
                vs2_b = vs2_q[k*BW +: BW];
                vdo_b = vdo_q[k*BW +: BW];
            end
        end
        op1_b = vv_q ? vs1_b : {(BW / 64){scal_q}};
    end

    vec_alu_beat #(.BW(BW)) u_beat (
        .opcode (opc_q),
        .vsew   (sew_q),
        .op1    (op1_b),
        .vs2    (vs2_b),
        .res    (res_b)
    );

    // Byte-granular mask/tail merge: each byte inherits its element's active status.
    always_comb begin
        merged_b = '0;
        g        = '0;
        idx      = '0;
        act      = 1'b0;
        vl32     = 32'(vl_q);
        vlmax    = 32'(VLEN) >> (32'd3 + 32'(sew_q));
        for (int b = 0; b < BW / 8; b++) begin
            g   = 32'(cnt_q) * 32'(BW / 8) + 32'(b);
            idx = g >> sew_q;
            act = (idx < vl32) && (idx < vlmax) && (vm_q || (|(v0_q & (VLEN'(1) << idx))));
            merged_b[b*8 +: 8] = act ? res_b[b*8 +: 8] : vdo_b[b*8 +: 8];
        end
    end

    // Result register: written beat by beat while running, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            vd_q <= '0;
        end else if (state_q == ST_RUN) begin
            for (int k = 0; k < B; k++) begin
                if (cnt_q == CW'(k)) vd_q[k*BW +: BW] <= merged_b;
            end
        end
    end

    // Illegal flag: set or cleared by each accepted request.
    always_ff @(posedge clk) begin
        if (reset)       ill_q <= 1'b0;
        else if (accept) ill_q <= !legal;
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign illegal = ill_q;
    assign vd      = vd_q;

endmodule

// File: tb/tb_vec_alu_multilane.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random vs model.
module tb_vec_alu_multilane;

    logic         clk = 1'b0;
    logic         reset, start, vm;
    logic [5:0]   opcode;
    logic [2:0]   op_type, vsew;
    logic [7:0]   vl;
    logic [127:0] vs1, vs2, v0, vd_old, vd;
    logic [31:0]  rs1;
    logic [4:0]   imm;
    logic         busy, done, illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] A = 128'habcdabcdbeefbeef1234567887654321;
    localparam logic [127:0] B = 128'h8765432112345678beefbeefabcdabcd;

    typedef struct {
        logic [5:0]   opc;
        logic [2:0]   opt;
        logic [2:0]   sew;
        logic         vm;
        logic [7:0]   vl;
        logic [127:0] vs1, vs2, v0, vdo;
        logic [31:0]  rs1;
        logic [4:0]   imm;
        logic [127:0] exp;
        logic         expill;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    vec_alu_multilane dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .op_type(op_type),
        .vsew(vsew), .vm(vm), .vl(vl), .vs1(vs1), .vs2(vs2), .v0(v0), .vd_old(vd_old),
        .rs1(rs1), .imm(imm), .busy(busy), .done(done), .illegal(illegal), .vd(vd)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] opc, input logic [2:0] opt, input logic [2:0] sew,
                                input logic vmi, input logic [7:0] vli, input logic [127:0] a,
                                input logic [127:0] b, input logic [127:0] m, input logic [127:0] old,
                                input logic [31:0] r, input logic [4:0] im, input logic [127:0] e,
                                input logic eill);
        vec_t v;
        v.opc = opc; v.opt = opt; v.sew = sew; v.vm = vmi; v.vl = vli;
        v.vs1 = a; v.vs2 = b; v.v0 = m; v.vdo = old; v.rs1 = r; v.imm = im;
        v.exp = e; v.expill = eill;
        return v;
    endfunction

    function automatic logic legal_req(input vec_t v);
        logic ok;
        ok = (v.opc inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11});
        ok = ok && (v.opt inside {3'b001, 3'b010, 3'b100}) && (v.sew <= 3'd3);
        ok = ok && !((v.opc == 6'd3) && (v.opt == 3'b001));
        return ok;
    endfunction

    // Reference: element-by-element arithmetic on the whole register.
    function automatic logic [127:0] model(input vec_t v, input logic [127:0] prev);
        int          ew, n, lim;
        logic [63:0] mask, a, b, r, old, scal;
        longint      sa, sb;
        logic [127:0] out;
        if (!legal_req(v)) return prev;
        ew   = 8 << v.sew;
        n    = 128 / ew;
        mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
        lim  = (int'(v.vl) > n) ? n : int'(v.vl);
        if (v.opt == 3'b100) scal = {{59{v.imm[4]}}, v.imm};
        else                 scal = {{32{v.rs1[31]}}, v.rs1};
        out = '0;
        for (int i = 0; i < n; i++) begin
            a   = 64'(v.vs2 >> (i * ew)) & mask;
            b   = (v.opt == 3'b001) ? (64'(v.vs1 >> (i * ew)) & mask) : (scal & mask);
            old = 64'(v.vdo >> (i * ew)) & mask;
            sa  = (ew < 64 && a[ew-1]) ? longint'(a | ~mask) : longint'(a);
            sb  = (ew < 64 && b[ew-1]) ? longint'(b | ~mask) : longint'(b);
            case (v.opc)
                6'd0:  r = a + b;
                6'd2:  r = a - b;
                6'd3:  r = b - a;
                6'd4:  r = (a < b) ? a : b;
                6'd5:  r = (sa < sb) ? a : b;
                6'd6:  r = (a > b) ? a : b;
                6'd7:  r = (sa > sb) ? a : b;
                6'd9:  r = a & b;
                6'd10: r = a | b;
                default: r = a ^ b;
            endcase
            r = r & mask;
            if (!(i < lim && (v.vm || v.v0[i]))) r = old;
            out = out | (128'(r) << (i * ew));
        end
        return out;
    endfunction

    task automatic drive(input vec_t v);
        opcode = v.opc; op_type = v.opt; vsew = v.sew; vm = v.vm; vl = v.vl;
        vs1 = v.vs1; vs2 = v.vs2; v0 = v.v0; vd_old = v.vdo; rs1 = v.rs1; imm = v.imm;
    endtask

    // One request; lat counts negedges after the start edge until done is seen.
    task automatic apply(input vec_t v, output logic [127:0] got, output logic gill, output int lat);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        got  = vd;
        gill = illegal;
    endtask

    logic [127:0] got, state_vd, hold_vd;
    logic         gill;
    int           lat;
    vec_t         v, w;
    logic [5:0]   ops[10] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};

    initial begin
        reset = 1'b1; start = 1'b0;
        drive(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[0]  = mk(6'd0, 3'b001, 3'd0, 1'b1, 8'd128, A, B, '0, '0, 32'd0, 5'd0,
                     128'h3232eeeed0231467d02314673232eeee, 1'b0);
        tbl[1]  = mk(6'd0, 3'b001, 3'd1, 1'b1, 8'd128, A, B, '0, '0, 32'd0, 5'd0,
                     128'h3332eeeed1231567d12315673332eeee, 1'b0);
        tbl[2]  = mk(6'd0, 3'b001, 3'd2, 1'b1, 8'd128, A, B, '0, '0, 32'd0, 5'd0,
                     128'h3332eeeed1241567d12415673332eeee, 1'b0);
        tbl[3]  = mk(6'd0, 3'b001, 3'd3, 1'b1, 8'd128, A, B, '0, '0, 32'd0, 5'd0,
                     128'h3332eeeed1241567d12415683332eeee, 1'b0);
        tbl[4]  = mk(6'd0, 3'b001, 3'd2, 1'b0, 8'd128, A, B, 128'h5, '1, 32'd0, 5'd0,
                     128'hffffffffd1241567ffffffff3332eeee, 1'b0);
        tbl[5]  = mk(6'd0, 3'b001, 3'd2, 1'b1, 8'd3, A, B, '0, '1, 32'd0, 5'd0,
                     128'hffffffffd1241567d12415673332eeee, 1'b0);
        tbl[6]  = mk(6'd0, 3'b100, 3'd0, 1'b1, 8'd128, A, '0, '0, '0, 32'd0, 5'h1f, '1, 1'b0);
        tbl[7]  = mk(6'd3, 3'b010, 3'd0, 1'b1, 8'd128, A, '0, '0, '0, 32'd1, 5'd0,
                     {16{8'h01}}, 1'b0);
        tbl[8]  = mk(6'd3, 3'b001, 3'd0, 1'b1, 8'd128, A, B, '0, '0, 32'd0, 5'd0,
                     {16{8'h01}}, 1'b1);
        tbl[9]  = mk(6'd0, 3'b001, 3'd4, 1'b1, 8'd128, A, B, '0, '0, 32'd0, 5'd0,
                     {16{8'h01}}, 1'b1);
        tbl[10] = mk(6'd11, 3'b001, 3'd0, 1'b1, 8'd200, A, B, '0, '0, 32'd0, 5'd0,
                     128'h2ca8e8ecacdbe897acdbe8972ca8e8ec, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_illegal", 128'(illegal), 128'd0);
        chk("reset_vd", vd, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i], got, gill, lat);
            chk($sformatf("tbl%0d_vd", i), got, tbl[i].exp);
            chk($sformatf("tbl%0d_illegal", i), 128'(gill), 128'(tbl[i].expill));
            chk($sformatf("tbl%0d_latency", i), 128'(lat), tbl[i].expill ? 128'd1 : 128'd3);
        end
        state_vd = tbl[10].exp;

        // done is a single-cycle pulse and vd holds afterwards.
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'd0);
        repeat (3) @(negedge clk);
        chk("vd_hold", vd, state_vd);

        // vl = 0 leaves vd equal to vd_old.
        v = mk(6'd0, 3'b001, 3'd1, 1'b1, 8'd0, A, B, '0, 128'h0123456789abcdef0f1e2d3c4b5a6978,
               32'd0, 5'd0, 128'h0123456789abcdef0f1e2d3c4b5a6978, 1'b0);
        apply(v, got, gill, lat);
        chk("vl0_vd", got, v.exp);
        chk("vl0_latency", 128'(lat), 128'd3);
        state_vd = v.exp;

        // start held high while busy: new operands must be ignored.
        @(negedge clk);
        drive(tbl[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        w = mk(6'd11, 3'b010, 3'd3, 1'b0, 8'd1, '1, '1, '0, '1, 32'hdeadbeef, 5'd7, '0, 1'b0);
        drive(w);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        start = 1'b0;
        chk("busy_ignore_vd", vd, tbl[0].exp);
        chk("busy_ignore_latency", 128'(lat), 128'd3);
        @(negedge clk);
        chk("busy_ignore_idle", 128'(busy), 128'd0);
        state_vd = tbl[0].exp;

        // Reset during the first RUN cycle discards the operation.
        @(negedge clk);
        drive(tbl[3]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("rst_mid_was_busy", 128'(busy), 128'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_done", 128'(done), 128'd0);
        chk("rst_mid_vd", vd, '0);

        // Reset wins over start on the same edge.
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_busy", 128'(busy), 128'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        state_vd = '0;

        // Randomized requests against the reference model.
        for (int i = 0; i < 60; i++) begin
            v.opc = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 9))
                0:       v.opt = 3'($urandom);
                1, 2, 3: v.opt = 3'b001;
                4, 5, 6: v.opt = 3'b010;
                default: v.opt = 3'b100;
            endcase
            v.sew = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            v.vm  = 1'($urandom);
            v.vl  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 200)) : 8'd128;
            v.vs1 = {$urandom, $urandom, $urandom, $urandom};
            v.vs2 = {$urandom, $urandom, $urandom, $urandom};
            v.v0  = {$urandom, $urandom, $urandom, $urandom};
            v.vdo = {$urandom, $urandom, $urandom, $urandom};
            v.rs1 = $urandom;
            v.imm = 5'($urandom);
            v.exp = model(v, state_vd);
            v.expill = !legal_req(v);
            apply(v, got, gill, lat);
            chk($sformatf("rnd%0d_vd op=%0h t=%0b sew=%0d", i, v.opc, v.opt, v.sew), got, v.exp);
            chk($sformatf("rnd%0d_illegal", i), 128'(gill), 128'(v.expill));
            chk($sformatf("rnd%0d_latency", i), 128'(lat), v.expill ? 128'd1 : 128'd3);
            state_vd = v.exp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
